// File: rtl/gcm_gctr_pkg.sv
// Shared types and helpers for the GCTR engine: FSM states, counter increment
// and partial-block byte masking.
package gcm_gctr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KS_REQ,
    KS_WAIT,
    KS_READY,
    FLUSH
  } state_t;

  localparam int DEF_BLK_BITS = 128;
  localparam int BLK_BYTES    = DEF_BLK_BITS / 8;

  // Helpers work on a wide container so one definition serves any BLK_BITS up to this.
  localparam int MAX_BLK_BITS = 512;
  typedef logic [MAX_BLK_BITS-1:0] wide_t;

  function automatic wide_t ctr_inc(input wide_t ctr, input int inc_bits);
    wide_t m;
    m = '0;
    for (int i = 0; i < MAX_BLK_BITS; i++) m[i] = (i < inc_bits);
    return (ctr & ~m) | ((ctr + wide_t'(1)) & m);
  endfunction

  // Byte 0 sits in the top byte of the block; zero or oversized counts mean a full block.
  function automatic wide_t byte_mask(input int nbytes, input int blk_bytes);
    wide_t m;
    int    n;
    m = '0;
    n = (nbytes == 0 || nbytes > blk_bytes) ? blk_bytes : nbytes;
    for (int b = 0; b < MAX_BLK_BITS / 8; b++)
      if (b < n) m[(blk_bytes - 1 - b) * 8 +: 8] = 8'hff;
    return m;
  endfunction

endpackage

// File: rtl/gcm_gctr_fifo.sv
// Small synchronous FIFO holding {result block, last flag}; registered storage,
// first word visible one cycle after the push.
module gcm_gctr_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gcm_gctr.sv
// GCTR engine: walks the counter from the ICB, fetches one keystream block per
// data block from the shared AES core (prefetching the next), XORs and masks.
module gcm_gctr
  import gcm_gctr_pkg::*;
#(
  parameter int BLK_BITS  = 128,
  parameter int INC_BITS  = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            key_expanded,
  input  logic [BLK_BITS-1:0]             icb,
  input  logic                            icb_valid,
  output logic                            icb_ready,
  input  logic [BLK_BITS-1:0]             in_blk,
  input  logic [$clog2(BLK_BITS/8):0]     in_bytes,
  input  logic                            in_last,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BLK_BITS-1:0]             out_blk,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BLK_BITS-1:0]             aes_alg_in_blk,
  output logic                            aes_alg_start,
  input  logic [BLK_BITS-1:0]             aes_alg_out_blk,
  input  logic                            aes_alg_done,
  output logic                            done
);

  localparam int NBYTES = BLK_BITS / 8;

  state_t              state_q, state_d;
  logic [BLK_BITS-1:0] ctr_q, ctr_d, ks_q, ks_d, aes_in_q, aes_in_d;
  logic [BLK_BITS-1:0] ctr_nxt, in_mask;
  logic                start_q, start_d, done_q, done_d;
  logic                fifo_full, fifo_empty, push, pop;
  logic [BLK_BITS:0]   fifo_din, fifo_dout;

  assign ctr_nxt  = BLK_BITS'(ctr_inc(wide_t'(ctr_q), INC_BITS));
  assign in_mask  = BLK_BITS'(byte_mask(int'(in_bytes), NBYTES));

  assign icb_ready = (state_q == IDLE);
  assign in_ready  = (state_q == KS_READY) && !fifo_full;
  assign push      = in_valid && in_ready;
  assign pop       = out_ready && !fifo_empty;
  assign fifo_din  = {(in_blk ^ ks_q) & in_mask, in_last};

  assign out_blk        = fifo_dout[BLK_BITS:1];
  assign out_last       = fifo_dout[0];
  assign out_valid      = !fifo_empty;
  assign aes_alg_start  = start_q;
  assign aes_alg_in_blk = aes_in_q;
  assign done           = done_q;

  // The start pulse is registered, so the request is issued on the same edge
  // the counter becomes known; KS_REQ only holds while the key schedule is not ready.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    ks_d     = ks_q;
    aes_in_d = aes_in_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (icb_valid) begin
          ctr_d = icb;
          if (key_expanded) begin
            start_d  = 1'b1;
            aes_in_d = icb;
            state_d  = KS_WAIT;
          end else begin
            state_d = KS_REQ;
          end
        end
      end
      KS_REQ: begin
        if (key_expanded) begin
          start_d  = 1'b1;
          aes_in_d = ctr_q;
          state_d  = KS_WAIT;
        end
      end
      KS_WAIT: begin
        if (aes_alg_done) begin
          ks_d    = aes_alg_out_blk;
          state_d = KS_READY;
        end
      end
      KS_READY: begin
        if (push) begin
          if (in_last) begin
            state_d = FLUSH;
          end else begin
            ctr_d = ctr_nxt;
            if (key_expanded) begin
              start_d  = 1'b1;
              aes_in_d = ctr_nxt;
              state_d  = KS_WAIT;
            end else begin
              state_d = KS_REQ;
            end
          end
        end
      end
      FLUSH: begin
        if (pop && fifo_dout[0]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      ks_q     <= '0;
      aes_in_q <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      ks_q     <= ks_d;
      aes_in_q <= aes_in_d;
      start_q  <= start_d;
      done_q   <= done_d;
    end
  end

  gcm_gctr_fifo #(
    .WIDTH(BLK_BITS + 1),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (fifo_din),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_gcm_gctr.sv
// Directed bench for gcm_gctr: single-block vector table plus hand-written
// multi-block sequences (counter, wrap, backpressure, key gating, reset).
module tb_gcm_gctr;

  localparam logic [127:0] KS0   = 128'hfe622563_62600ac7_66636f96_2bb05f66;
  localparam logic [127:0] KS1   = 128'h69488eec_2890c5c6_bd0781a5_4b252bdc;
  localparam logic [127:0] KS2   = 128'h01234567_89abcdef_00112233_44556677;
  localparam logic [127:0] KS3   = 128'h8899aabb_ccddeeff_0f1e2d3c_4b5a6978;
  localparam logic [127:0] ICB_A = 128'hcafebabe_facedbad_decaf888_00000001;
  localparam logic [127:0] ICB_W = 128'hcafebabe_facedbad_decaf888_ffffffff;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_expanded = 1'b1;
  logic [127:0] icb = '0;
  logic         icb_valid = 1'b0;
  logic         icb_ready;
  logic [127:0] in_blk = '0;
  logic [4:0]   in_bytes = '0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_blk;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] aes_alg_in_blk;
  logic         aes_alg_start;
  logic [127:0] aes_alg_out_blk;
  logic         aes_alg_done;
  logic         done;

  logic         m_done = 1'b0;
  logic [127:0] m_out = '0;
  logic         spur = 1'b0;
  logic         busy = 1'b0;
  int           wcnt = 0;
  int           ks_idx = 0;
  int           n_done = 0;
  int           overlap = 0;
  logic [127:0] req_q [$];
  logic [128:0] pop_q [$];

  int n_tests = 0;
  int n_fail = 0;

  assign aes_alg_done    = m_done | spur;
  assign aes_alg_out_blk = spur ? '1 : m_out;

  always #5 clk = ~clk;

  gcm_gctr #(.BLK_BITS(128), .INC_BITS(32), .OUT_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .key_expanded   (key_expanded),
    .icb            (icb),
    .icb_valid      (icb_valid),
    .icb_ready      (icb_ready),
    .in_blk         (in_blk),
    .in_bytes       (in_bytes),
    .in_last        (in_last),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_blk        (out_blk),
    .out_last       (out_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .aes_alg_in_blk (aes_alg_in_blk),
    .aes_alg_start  (aes_alg_start),
    .aes_alg_out_blk(aes_alg_out_blk),
    .aes_alg_done   (aes_alg_done),
    .done           (done)
  );

  function automatic logic [127:0] ks_of(input int i);
    case (i % 4)
      0:       return KS0;
      1:       return KS1;
      2:       return KS2;
      default: return KS3;
    endcase
  endfunction

  // AES model (16-cycle latency, fixed keystream sequence) and output monitor.
  always @(negedge clk) begin
    if (reset) begin
      busy   = 1'b0;
      m_done = 1'b0;
      ks_idx = 0;
      n_done = 0;
      req_q.delete();
      pop_q.delete();
    end else begin
      m_done = 1'b0;
      if (aes_alg_start) begin
        if (busy) overlap++;
        busy = 1'b1;
        wcnt = 0;
        req_q.push_back(aes_alg_in_blk);
      end else if (busy) begin
        wcnt++;
        if (wcnt == 16) begin
          m_done = 1'b1;
          m_out  = ks_of(ks_idx);
          ks_idx++;
          busy   = 1'b0;
        end
      end
      if (out_valid && out_ready) pop_q.push_back({out_last, out_blk});
      if (done) n_done++;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_icb(input logic [127:0] v);
    for (int i = 0; i < 100 && !icb_ready; i++) tick();
    if (!icb_ready) chk("icb_ready_timeout", {255'd0, icb_ready}, 256'd1);
    icb       = v;
    icb_valid = 1'b1;
    tick();
    icb_valid = 1'b0;
  endtask

  task automatic wait_in_ready();
    for (int i = 0; i < 400 && !in_ready; i++) tick();
    if (!in_ready) chk("in_ready_timeout", {255'd0, in_ready}, 256'd1);
  endtask

  task automatic send_blk(input logic [127:0] d, input logic [4:0] nb, input logic last);
    wait_in_ready();
    in_blk   = d;
    in_bytes = nb;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && n_done == 0; i++) tick();
    repeat (3) tick();
  endtask

  function automatic logic [127:0] req_at(input int i);
    if (i < req_q.size()) return req_q[i];
    return 'x;
  endfunction

  function automatic logic [128:0] pop_at(input int i);
    if (i < pop_q.size()) return pop_q[i];
    return 'x;
  endfunction

  typedef struct {
    logic [127:0] icb;
    logic [127:0] din;
    logic [4:0]   nb;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    gcm_gctr_pkg::wide_t w;
    logic [127:0] r;

    vecs[0] = '{128'h0, 128'h0, 5'd16, KS0};
    vecs[1] = '{ICB_A, '1, 5'd3, 128'h019dda00_00000000_00000000_00000000};
    vecs[2] = '{'1, '1, 5'd0, 128'h019dda9c_9d9ff538_999c9069_d44fa099};
    vecs[3] = '{128'h01234567_89abcdef_01234567_89abcdef, KS0, 5'd16, 128'h0};
    vecs[4] = '{ICB_W, 128'h0, 5'd1, 128'hfe000000_00000000_00000000_00000000};
    vecs[5] = '{ICB_A, 128'h0, 5'd15, 128'hfe622563_62600ac7_66636f96_2bb05f00};
    vecs[6] = '{ICB_A, 128'h00112233_44556677_8899aabb_ccddeeff, 5'd8,
                128'hfe730750_26356cb0_00000000_00000000};

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("rst_out_blk", {127'd0, out_last, out_blk}, 256'd0);
    chk("rst_start", {255'd0, aes_alg_start}, 256'd0);
    chk("rst_aes_in", {128'd0, aes_alg_in_blk}, 256'd0);
    chk("rst_done", {255'd0, done}, 256'd0);
    chk("rst_ready", {254'd0, icb_ready, in_ready}, 256'd2);
    tick();
    reset = 1'b0;
    tick();

    // Spurious AES completion in IDLE is ignored.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_idle", {254'd0, icb_ready, in_ready}, 256'd2);

    // Counter increment helper with a narrow field and with a full-width field.
    w = gcm_gctr_pkg::wide_t'(128'hcafebabe_facedbad_decaf888_000012ff);
    r = 128'(gcm_gctr_pkg::ctr_inc(w, 8));
    chk("inc8_wrap", {128'd0, r}, {128'd0, 128'hcafebabe_facedbad_decaf888_00001200});
    w = gcm_gctr_pkg::wide_t'({128{1'b1}});
    r = 128'(gcm_gctr_pkg::ctr_inc(w, 128));
    chk("inc128_wrap", {128'd0, r}, 256'd0);

    // Table: single-block messages.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      out_ready    = 1'b1;
      key_expanded = 1'b1;
      send_icb(vecs[v].icb);
      send_blk(vecs[v].din, vecs[v].nb, 1'b1);
      wait_done();
      chk($sformatf("vec%0d_req", v), {128'd0, req_at(0)}, {128'd0, vecs[v].icb});
      chk($sformatf("vec%0d_out", v), {127'd0, pop_at(0)}, {127'd0, 1'b1, vecs[v].exp});
      chk($sformatf("vec%0d_done", v), 256'(n_done), 256'd1);
    end

    // Two-block message: counter path, latencies, prefetch, spurious done in KS_READY.
    do_reset();
    send_icb(ICB_A);
    chk("a_icb_start", {255'd0, aes_alg_start}, 256'd1);
    wait_in_ready();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    send_blk(128'h0, 5'd16, 1'b0);
    chk("a_out_valid_lat", {255'd0, out_valid}, 256'd1);
    chk("a_prefetch_start", {255'd0, aes_alg_start}, 256'd1);
    send_blk(128'h0, 5'd16, 1'b1);
    wait_done();
    chk("a_req0", {128'd0, req_at(0)}, {128'd0, ICB_A});
    chk("a_req1", {128'd0, req_at(1)}, {128'd0, 128'hcafebabe_facedbad_decaf888_00000002});
    chk("a_out0", {127'd0, pop_at(0)}, {127'd0, 1'b0, KS0});
    chk("a_out1", {127'd0, pop_at(1)}, {127'd0, 1'b1, KS1});
    chk("a_done", 256'(n_done), 256'd1);

    // Backpressure with a full output FIFO.
    do_reset();
    out_ready = 1'b0;
    send_icb(ICB_A);
    send_blk(128'h0, 5'd16, 1'b0);
    send_blk(128'h0, 5'd16, 1'b0);
    repeat (60) tick();
    chk("bp_in_ready", {255'd0, in_ready}, 256'd0);
    chk("bp_out_valid", {255'd0, out_valid}, 256'd1);
    chk("bp_nreq", 256'(req_q.size()), 256'd3);
    chk("bp_req2", {128'd0, req_at(2)}, {128'd0, 128'hcafebabe_facedbad_decaf888_00000003});
    out_ready = 1'b1;
    chk("bp_no_bypass", {255'd0, in_ready}, 256'd0);
    send_blk(128'h0, 5'd16, 1'b0);
    send_blk(128'h0, 5'd16, 1'b1);
    wait_done();
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_out%0d", i), {127'd0, pop_at(i)}, {127'd0, (i == 3), ks_of(i)});
    chk("bp_done", 256'(n_done), 256'd1);

    // Key schedule gating.
    do_reset();
    key_expanded = 1'b0;
    send_icb(ICB_A);
    repeat (20) tick();
    chk("kg_no_start", 256'(req_q.size()), 256'd0);
    key_expanded = 1'b1;
    tick();
    chk("kg_start", {255'd0, aes_alg_start}, 256'd1);
    send_blk('1, 5'd3, 1'b1);
    wait_done();
    chk("kg_out", {127'd0, pop_at(0)}, {127'd0, 1'b1, 128'h019dda00_00000000_00000000_00000000});

    // Reset between blocks, then a fresh message whose counter wraps.
    do_reset();
    send_icb(ICB_A);
    send_blk(128'h0, 5'd16, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("mr_out_valid", {255'd0, out_valid}, 256'd0);
    chk("mr_out_blk", {127'd0, out_last, out_blk}, 256'd0);
    chk("mr_start", {255'd0, aes_alg_start}, 256'd0);
    chk("mr_aes_in", {128'd0, aes_alg_in_blk}, 256'd0);
    chk("mr_ready", {254'd0, icb_ready, in_ready}, 256'd2);
    tick();
    reset = 1'b0;
    repeat (30) tick();
    chk("mr_no_done", 256'(n_done), 256'd0);
    send_icb(ICB_W);
    send_blk(128'h0, 5'd16, 1'b0);
    send_blk(128'h0, 5'd16, 1'b1);
    wait_done();
    chk("wr_req1", {128'd0, req_at(1)}, {128'd0, 128'hcafebabe_facedbad_decaf888_00000000});
    chk("wr_out0", {127'd0, pop_at(0)}, {127'd0, 1'b0, KS0});
    chk("wr_out1", {127'd0, pop_at(1)}, {127'd0, 1'b1, KS1});
    chk("wr_done", 256'(n_done), 256'd1);
    chk("one_outstanding", 256'(overlap), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
